// File: rtl/conv_pool_stage_if.sv
// Stream bundle between the convolution channel and the pooling stage.
// master drives dims + conv beats; slave returns pooled samples + status.
interface conv_pool_stage_if #(
    parameter int DataWidth = 64
);
    logic [8:0]                  row_in;
    logic [8:0]                  col_in;
    logic signed [DataWidth-1:0] result_in;
    logic                        result_valid;
    logic signed [DataWidth-1:0] pool_out;
    logic                        pool_valid;
    logic                        frame_done;
    logic                        cfg_err;

    modport master (
        output row_in, col_in, result_in, result_valid,
        input  pool_out, pool_valid, frame_done, cfg_err
    );

    modport slave (
        input  row_in, col_in, result_in, result_valid,
        output pool_out, pool_valid, frame_done, cfg_err
    );
endinterface

// File: rtl/conv_pool_stage.sv
// 2x2 stride-2 max pooling (optional ReLU) over a row-major conv stream.
// Ports: Clk, Rst (async low), bus (slave: dims/beats in, pooled/status out).
module conv_pool_stage #(
    parameter int DataWidth = 64,
    parameter int MaxCol    = 256,
    parameter bit ReluEn    = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    conv_pool_stage_if.slave bus
);
    localparam int BufDepth = MaxCol / 2;
    localparam int IdxW     = (BufDepth > 1) ? $clog2(BufDepth) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [8:0] rows_q, cols_q;
    logic [8:0] row_cnt, col_cnt;
    logic [8:0] rows_eff, cols_eff;

    logic signed [DataWidth-1:0] pair_q;
    logic signed [DataWidth-1:0] pool_q;
    logic                        pool_v_q;
    logic                        done_q;

    logic signed [DataWidth-1:0] line_buf [BufDepth];

    logic            beat;
    logic            bad;
    logic            take;
    logic            last_col;
    logic            last_row;
    logic [IdxW-1:0] idx;

    logic signed [DataWidth-1:0] pm;
    logic signed [DataWidth-1:0] m;

    function automatic logic signed [DataWidth-1:0] smax(
        input logic signed [DataWidth-1:0] a,
        input logic signed [DataWidth-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // The first beat of a frame uses the live dims; later beats the latched.
    always_comb begin
        rows_eff = (state_q == S_IDLE) ? bus.row_in : rows_q;
        cols_eff = (state_q == S_IDLE) ? bus.col_in : cols_q;
    end

    assign bad = (rows_eff == 9'd0) || (cols_eff == 9'd0)
               || (int'(cols_eff) > MaxCol);

    assign beat     = bus.result_valid && (state_q != S_ERR);
    assign take     = beat && !((state_q == S_IDLE) && bad);
    assign last_col = (col_cnt == cols_eff - 9'd1);
    assign last_row = (row_cnt == rows_eff - 9'd1);
    assign idx      = col_cnt[IdxW:1];

    assign pm = smax(pair_q, bus.result_in);
    assign m  = smax(line_buf[idx], pm);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (beat) begin
                    if (bad) begin
                        state_d = S_ERR;
                    end else if (!(last_col && last_row)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (take && last_col && last_row) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rows_q   <= '0;
            cols_q   <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            pair_q   <= '0;
            pool_q   <= '0;
            pool_v_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pool_v_q <= 1'b0;
            done_q   <= 1'b0;
            if (beat && (state_q == S_IDLE)) begin
                rows_q <= bus.row_in;
                cols_q <= bus.col_in;
            end
            if (take) begin
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? 9'd0 : row_cnt + 9'd1;
                end else begin
                    col_cnt <= col_cnt + 9'd1;
                end
                if (!col_cnt[0]) begin
                    pair_q <= bus.result_in;
                end else if (row_cnt[0]) begin
                    pool_v_q <= 1'b1;
                    pool_q   <= (ReluEn && m[DataWidth-1]) ? '0 : m;
                end
                done_q <= last_col && last_row;
            end
        end
    end

    // Every entry is rewritten in an even row before the odd row reads it.
    always_ff @(posedge Clk) begin
        if (take && col_cnt[0] && !row_cnt[0]) begin
            line_buf[idx] <= pm;
        end
    end

    assign bus.pool_out   = pool_q;
    assign bus.pool_valid = pool_v_q;
    assign bus.frame_done = done_q;
    assign bus.cfg_err    = (state_q == S_ERR);
endmodule

// File: tb/tb_conv_pool_stage.sv
// Scoreboard bench for conv_pool_stage: ReLU and pass-through instances.
// Driver pushes window maxima with expected cycle; negedge monitor checks.
module tb_conv_pool_stage;
    localparam int DW = 64;
    localparam int MC = 256;

    typedef struct {
        logic signed [DW-1:0] v;
        int                   cyc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q1[$];
    exp_t q0[$];
    int   fd1[$];
    int   fd0[$];

    logic signed [DW-1:0] img [16][256];

    always #5 Clk = ~Clk;

    conv_pool_stage_if #(.DataWidth(DW)) ifc1();
    conv_pool_stage_if #(.DataWidth(DW)) ifc0();

    assign ifc0.row_in       = ifc1.row_in;
    assign ifc0.col_in       = ifc1.col_in;
    assign ifc0.result_in    = ifc1.result_in;
    assign ifc0.result_valid = ifc1.result_valid;

    conv_pool_stage #(.DataWidth(DW), .MaxCol(MC), .ReluEn(1'b1)) dut1 (
        .Clk(Clk),
        .Rst(Rst),
        .bus(ifc1.slave)
    );

    conv_pool_stage #(.DataWidth(DW), .MaxCol(MC), .ReluEn(1'b0)) dut0 (
        .Clk(Clk),
        .Rst(Rst),
        .bus(ifc0.slave)
    );

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] max4(
        input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
        input logic signed [DW-1:0] c, input logic signed [DW-1:0] d);
        logic signed [DW-1:0] r;
        r = a;
        if (b > r) r = b;
        if (c > r) r = c;
        if (d > r) r = d;
        return r;
    endfunction

    // Monitor: every strobe must match the head of its queue, value and cycle.
    initial forever begin
        exp_t e;
        int   f;
        @(negedge Clk);
        if (Rst) begin
            if (ifc1.pool_valid) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL relu_unexpected got %0d", ifc1.pool_out);
                end else begin
                    e = q1.pop_front();
                    if (ifc1.pool_out !== e.v || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL relu_out got %0d@%0d expected %0d@%0d",
                                 ifc1.pool_out, cyc, e.v, e.cyc);
                    end
                end
            end
            if (ifc0.pool_valid) begin
                tests++;
                if (q0.size() == 0) begin
                    fails++;
                    $display("FAIL raw_unexpected got %0d", ifc0.pool_out);
                end else begin
                    e = q0.pop_front();
                    if (ifc0.pool_out !== e.v || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL raw_out got %0d@%0d expected %0d@%0d",
                                 ifc0.pool_out, cyc, e.v, e.cyc);
                    end
                end
            end
            if (ifc1.frame_done) begin
                tests++;
                f = (fd1.size() == 0) ? -1 : fd1.pop_front();
                if (f != cyc) begin
                    fails++;
                    $display("FAIL relu_done got cycle %0d expected %0d", cyc, f);
                end
            end
            if (ifc0.frame_done) begin
                tests++;
                f = (fd0.size() == 0) ? -1 : fd0.pop_front();
                if (f != cyc) begin
                    fails++;
                    $display("FAIL raw_done got cycle %0d expected %0d", cyc, f);
                end
            end
        end
    end

    task automatic idle();
        @(posedge Clk);
        #1;
        ifc1.result_valid = 1'b0;
    endtask

    // kind: 0 ramp, 1 all -1, 2 random; gap: 0 none, 1 alternate, 2 random.
    task automatic run_frame(input int rows, input int cols, input int kind,
                             input int gap, input int maxb);
        int n;
        logic signed [DW-1:0] mx;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                case (kind)
                    0: img[r][c] = DW'(r * cols + c);
                    1: img[r][c] = -1;
                    default: img[r][c] = {$urandom, $urandom};
                endcase
            end
        end
        n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (maxb != 0 && n == maxb) return;
                if (n > 0 && gap == 1) idle();
                if (n > 0 && gap == 2) repeat ($urandom_range(0, 2)) idle();
                @(posedge Clk);
                #1;
                ifc1.row_in       = 9'(rows);
                ifc1.col_in       = 9'(cols);
                ifc1.result_in    = img[r][c];
                ifc1.result_valid = 1'b1;
                if (r % 2 == 1 && c % 2 == 1
                    && r < (rows / 2) * 2 && c < (cols / 2) * 2) begin
                    mx = max4(img[r-1][c-1], img[r-1][c],
                              img[r][c-1], img[r][c]);
                    q0.push_back('{mx, cyc + 1});
                    q1.push_back('{(mx < 0) ? '0 : mx, cyc + 1});
                end
                if (r == rows - 1 && c == cols - 1) begin
                    fd1.push_back(cyc + 1);
                    fd0.push_back(cyc + 1);
                end
                n++;
            end
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_out1", ifc1.pool_out, 0);
        chk("rst_valid1", ifc1.pool_valid, 0);
        chk("rst_done1", ifc1.frame_done, 0);
        chk("rst_err1", ifc1.cfg_err, 0);
        chk("rst_out0", ifc0.pool_out, 0);
        chk("rst_valid0", ifc0.pool_valid, 0);
    endtask

    initial begin
        ifc1.row_in       = '0;
        ifc1.col_in       = '0;
        ifc1.result_in    = '0;
        ifc1.result_valid = 1'b0;
        repeat (2) @(negedge Clk);
        chk_reset_state();
        @(posedge Clk);
        #1 Rst = 1'b1;

        run_frame(4, 4, 0, 0, 0);
        run_frame(5, 5, 0, 0, 0);
        run_frame(4, 4, 1, 0, 0);
        idle();
        run_frame(4, 4, 0, 1, 0);
        idle();

        run_frame(4, 4, 0, 0, 6);
        idle();
        idle();
        Rst = 1'b0;
        @(negedge Clk);
        chk_reset_state();
        @(posedge Clk);
        #1 Rst = 1'b1;
        run_frame(6, 6, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            run_frame($urandom_range(1, 9), $urandom_range(1, 14), 2,
                      $urandom_range(0, 2), 0);
            if ($urandom_range(0, 1) == 1) idle();
        end
        run_frame(2, MC, 2, 0, 0);
        run_frame(1, 1, 2, 0, 0);
        run_frame(3, 1, 2, 2, 0);
        run_frame(2, 2, 2, 0, 0);
        idle();
        repeat (3) idle();

        @(posedge Clk);
        #1;
        ifc1.row_in       = 9'd4;
        ifc1.col_in       = 9'd300;
        ifc1.result_in    = 64'sd1;
        ifc1.result_valid = 1'b1;
        repeat (9) begin
            @(posedge Clk);
            #1 ifc1.result_in = {$urandom, $urandom};
        end
        @(negedge Clk);
        chk("err_set1", ifc1.cfg_err, 1);
        chk("err_set0", ifc0.cfg_err, 1);
        idle();
        repeat (3) @(negedge Clk);
        chk("err_sticky1", ifc1.cfg_err, 1);
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("err_clr1", ifc1.cfg_err, 0);
        chk("err_clr0", ifc0.cfg_err, 0);
        @(posedge Clk);
        #1 Rst = 1'b1;
        run_frame(2, 4, 2, 0, 0);
        idle();
        repeat (4) idle();

        chk("q_relu_empty", 64'(q1.size()), 0);
        chk("q_raw_empty", 64'(q0.size()), 0);
        chk("fd_relu_empty", 64'(fd1.size()), 0);
        chk("fd_raw_empty", 64'(fd0.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
